inv_mix_col_seq: RTL and testbench
==================================

Name: inv_mix_col_seq

Overview:
Iterative AES InvMixColumns engine for the decrypt datapath. It is the inverse of the existing 256-bit combinational mixCol stage.
- Accepts a 256-bit state (8 columns × 32 bits) over a valid/ready handshake.
- Transforms one column per clock through a shared column unit.
- Returns the result over a second valid/ready handshake.

Parameters:
NUM_COLS, 8, number of 32-bit columns per block; BLOCK_W = 32*NUM_COLS (default 256)
CNT_W, 3, width of the column counter; must satisfy 2**CNT_W >= NUM_COLS

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  in_data is valid
in_ready  out  1  engine can accept a block
in_data  in  BLOCK_W  ciphertext-side state; column k = bits [BLOCK_W-1-32k : BLOCK_W-32-32k]
out_valid  out  1  out_data holds a finished block
out_ready  in  1  consumer accepts out_data
out_data  out  BLOCK_W  InvMixColumns(in_data), same column/byte layout
busy  out  1  high while in state BUSY

Behaviour:
- Byte order: within a column, byte a0 = MSB byte, a3 = LSB byte.
- Per column: b_r = 0E·a_r ^ 0B·a_(r+1) ^ 0D·a_(r+2) ^ 09·a_(r+3), indices mod 4.
  - Arithmetic in GF(2^8) with polynomial 0x11B.
  - Multiplication is built from xtime chains; no lookup tables.
- FSM states: IDLE, BUSY, DONE. Reset state: IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load in_data into the shift register, cnt←0, go to BUSY.
- BUSY, every edge:
  - Top column (MSBs) passes through inv_mixer_col.
  - Register shifts left 32 bits; the result enters at the LSBs; cnt++.
  - When cnt==NUM_COLS-1 on that edge: go to DONE, out_valid←1.
- Latency: out_valid rises NUM_COLS edges after the accepting edge (8 by default).
- DONE:
  - out_data equals the shift register and is held stable while out_valid && !out_ready.
  - On out_valid&&out_ready: out_valid←0, go to IDLE.
  - in_ready reasserts the following cycle; there is no same-cycle re-accept.
  - Throughput: one block per NUM_COLS+2 cycles minimum.
- in_ready=0 in BUSY and DONE. in_valid and in_data are ignored there and never corrupt the block in flight.
- in_valid deasserting after acceptance has no effect.
- Reset values (any cycle rst_n=0): state IDLE, cnt 0, out_valid 0, out_data 0, busy 0. in_ready is gated to 0 while rst_n=0.
- Reset mid-operation: the in-flight block is discarded and no out_valid pulse occurs.
- out_ready high while out_valid=0 has no effect.
- X-free: out_data is driven from a register at all times.

Optional Feature:
INV_MIXCOL_DUAL_EN
- Defined:
  - Two inv_mixer_col instances transform the top two columns per edge; the register shifts 64 bits.
  - BUSY lasts NUM_COLS/2 edges; latency is 4 edges by default.
  - NUM_COLS must be even; an odd value triggers an elaboration-time $error.
- Undefined: single unit, one column per edge, as described above.
- Handshake and reset behaviour are identical in both builds.

Decomposition:
- Package aes_pkg holds:
  - constants GF_POLY=8'h1B, COL_W=32, BYTE_W=8;
  - state enum {IDLE, BUSY, DONE};
  - functions xtime(), gmul9/0B/0D/0E().
- Sub-module inv_mixer_col: combinational, 32-bit in → 32-bit out, one column.
  - Reused later by the full decrypt round.
- Top module inv_mix_col_seq: FSM, counter, shift register, handshakes.

Test Plan:
- All 8 columns = 8e4da1bc → every out column = db135345; out_valid rises 8 edges after accept (4 with INV_MIXCOL_DUAL_EN).
- Columns 9fdc589d, 01010101, c6c6c6c6, d5d5d7d6, 4d7ebdf8, 8e4da1bc, 9fdc589d, 01010101 → columns f20a225c, 01010101, c6c6c6c6, d4d4d4d5, 2d26314c, db135345, f20a225c, 01010101 in the same positions.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_data stable, in_ready=0 throughout, second in_valid pulse ignored; out_ready=1 → out_valid=0 next edge, in_ready=1 one cycle later.
- Reset mid-block: rst_n=0 for one edge at cnt=3 → out_valid stays 0, state IDLE, out_data=0; next block processes correctly.
- Round trip: 1000 random blocks through mixCol then inv_mix_col_seq, random in_valid/out_ready gaps → output equals original block, no drops or duplicates.
- Back-to-back: in_valid held high, out_ready=1 → accepted blocks spaced exactly NUM_COLS+2 cycles apart.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) multiply helpers built from xtime chains.
package aes_pkg;

  localparam logic [7:0] GF_POLY = 8'h1B;
  localparam int         COL_W   = 32;
  localparam int         BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] b);
    gmul09 = xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] b);
    gmul0b = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] b);
    gmul0d = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] b);
    gmul0e = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/inv_mixer_col.sv
// Combinational InvMixColumns for one 32-bit column; byte 0 is the MSB byte.
import aes_pkg::*;

module inv_mixer_col (
  input  logic [COL_W-1:0] col,
  output logic [COL_W-1:0] res
);

  // Each output byte is a fixed GF(2^8) combination of the column rotated by r
  for (genvar r = 0; r < 4; r++) begin : g_byte
    assign res[COL_W-1-BYTE_W*r -: BYTE_W] =
        gmul0e(col[COL_W-1-BYTE_W*r           -: BYTE_W]) ^
        gmul0b(col[COL_W-1-BYTE_W*((r+1) % 4) -: BYTE_W]) ^
        gmul0d(col[COL_W-1-BYTE_W*((r+2) % 4) -: BYTE_W]) ^
        gmul09(col[COL_W-1-BYTE_W*((r+3) % 4) -: BYTE_W]);
  end

endmodule

// File: rtl/inv_mix_col_seq.sv
// Iterative InvMixColumns engine: one column per clock through a shared column unit.
// Define INV_MIXCOL_DUAL_EN to process two columns per clock with two units.
import aes_pkg::*;

module inv_mix_col_seq #(
  parameter  int NUM_COLS = 8,
  parameter  int CNT_W    = 3,
  localparam int BLOCK_W  = COL_W * NUM_COLS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

`ifdef INV_MIXCOL_DUAL_EN
  localparam int LANES = 2;
  if (NUM_COLS % 2 != 0) begin : g_odd_cols
    $error("inv_mix_col_seq: NUM_COLS must be even in the dual-unit build");
  end
`else
  localparam int LANES = 1;
`endif

  if ((1 << CNT_W) < NUM_COLS) begin : g_cnt_too_small
    $error("inv_mix_col_seq: CNT_W too narrow for NUM_COLS");
  end

  localparam int               STEP_W   = COL_W * LANES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_COLS / LANES - 1);

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [BLOCK_W-1:0] data_r, data_s;
  logic               out_valid_r, out_valid_s;
  logic [STEP_W-1:0]  mixed_s;

  // Top columns of the shift register feed the column units; results keep their order
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_mixer_col u_col (
      .col (data_r[BLOCK_W-1-COL_W*l -: COL_W]),
      .res (mixed_s[STEP_W-1-COL_W*l -: COL_W])
    );
  end

  // Next-state, counter and shift-register update
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    data_s      = data_r;
    out_valid_s = out_valid_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = BUSY;
          cnt_s   = {CNT_W{1'b0}};
          data_s  = in_data;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        data_s = {data_r[BLOCK_W-STEP_W-1:0], mixed_s};
        cnt_s  = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_LAST) begin
          state_s     = DONE;
          out_valid_s = 1'b1;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s     = IDLE;
          out_valid_s = 1'b0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s     = IDLE;
        cnt_s       = {CNT_W{1'b0}};
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      data_r      <= {BLOCK_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      data_r      <= data_s;
      out_valid_r <= out_valid_s;
    end
  end

  // in_ready is gated by rst_n so nothing is accepted during reset
  assign in_ready  = rst_n && (state_r == IDLE);
  assign busy      = (state_r == BUSY);
  assign out_valid = out_valid_r;
  assign out_data  = data_r;

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// Self-checking bench for inv_mix_col_seq: GF(2^8) matrix model, scoreboard, round trip via MixColumns.
module tb_inv_mix_col_seq;

  localparam int NUM_COLS = 8;
  localparam int BLOCK_W  = 32 * NUM_COLS;
`ifdef INV_MIXCOL_DUAL_EN
  localparam int LAT = NUM_COLS / 2;
`else
  localparam int LAT = NUM_COLS;
`endif
  localparam int SPACING = LAT + 2;
  localparam int N_RT    = 1000;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int nrecv = 0;
  bit rt_mode = 1'b0;
  bit ov_prev = 1'b0;

  logic [BLOCK_W-1:0] exp_q[$];
  logic [BLOCK_W-1:0] orig_q[$];
  int                 acc_q[$];

  inv_mix_col_seq #(.NUM_COLS(NUM_COLS), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: GF(2^8) by long multiplication ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] mat_col(input logic [31:0] c, input logic [31:0] coefs);
    logic [7:0]  a [4];
    logic [7:0]  k [4];
    logic [7:0]  acc;
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      a[i] = c[31-8*i -: 8];
      k[i] = coefs[31-8*i -: 8];
    end
    for (int row = 0; row < 4; row++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(k[j], a[(row + j) % 4]);
      r[31-8*row -: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_block(input logic [BLOCK_W-1:0] b);
    logic [BLOCK_W-1:0] r;
    for (int k = 0; k < NUM_COLS; k++)
      r[BLOCK_W-1-32*k -: 32] = mat_col(b[BLOCK_W-1-32*k -: 32], 32'h0E0B0D09);
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_block(input logic [BLOCK_W-1:0] b);
    logic [BLOCK_W-1:0] r;
    for (int k = 0; k < NUM_COLS; k++)
      r[BLOCK_W-1-32*k -: 32] = mat_col(b[BLOCK_W-1-32*k -: 32], 32'h02030101);
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] rand_blk();
    logic [BLOCK_W-1:0] r;
    for (int k = 0; k < NUM_COLS; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // ---------------- monitor: scoreboard push on accept, pop on delivery ----------------
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        nrecv++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (rt_mode) begin
          if (orig_q.size() == 0) chk("roundtrip_extra", 1'b1, 1'b0);
          else chk("roundtrip", out_data, orig_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(inv_block(in_data));
        acc_cyc = cyc;
        acc_q.push_back(cyc);
      end
    end
  end

  // ---------------- compare process on the falling edge ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1'b1, 1'b0);
        else chk("out_data", out_data, exp_q[0]);
      end
      if (busy || out_valid) chk("in_ready_low_when_occupied", in_ready, 1'b0);
      if (out_valid && !ov_prev) chk("latency", cyc - acc_cyc, LAT);
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [BLOCK_W-1:0] d);
    int t;
    in_data  = d;
    in_valid = 1'b1;
    for (t = 0; t < 200 && !in_ready; t++) @(negedge clk);
    if (!in_ready) chk("accept_timeout", 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [BLOCK_W-1:0] d);
    int t;
    for (t = 0; t < 200 && !out_valid; t++) @(negedge clk);
    if (!out_valid) chk("out_valid_timeout", 1'b1, 1'b0);
    d = out_data;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BLOCK_W-1:0] v1, e1, v2, e2, r, held;
    v1 = {NUM_COLS{32'h8e4da1bc}};
    e1 = {NUM_COLS{32'hdb135345}};
    v2 = {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6,
          32'h4d7ebdf8, 32'h8e4da1bc, 32'h9fdc589d, 32'h01010101};
    e2 = {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5,
          32'h2d26314c, 32'hdb135345, 32'hf20a225c, 32'h01010101};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_out_data", out_data, '0);
    chk("reset_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);

    // pin the model itself against known vectors
    chk("model_inv_v1", inv_block(v1), e1);
    chk("model_inv_v2", inv_block(v2), e2);
    chk("model_fwd_v2", mix_block(e2), v2);

    // basic vectors with immediate consumer
    out_ready = 1'b1;
    send(v1);
    wait_out(r);
    chk("vec1_literal", r, e1);
    @(negedge clk);
    chk("vec1_out_valid_drop", out_valid, 1'b0);
    chk("vec1_in_ready_back", in_ready, 1'b1);
    send(v2);
    wait_out(r);
    chk("vec2_literal", r, e2);
    @(negedge clk);

    // backpressure: output held, second block ignored
    out_ready = 1'b0;
    send(v2);
    wait_out(held);
    chk("bp_literal", held, e2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stable", out_data, held);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      if (i == 1) begin in_valid = 1'b1; in_data = rand_blk(); end
      else if (i == 2) in_valid = 1'b0;
      else in_valid = in_valid;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", out_valid, 1'b0);
    chk("bp_release_in_ready", in_ready, 1'b1);

    // reset mid-block at cnt==3
    send(v1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_data", out_data, '0);
    chk("midrst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      chk("midrst_no_pulse", out_valid, 1'b0);
    end
    chk("midrst_idle", {busy, in_ready}, 2'b01);
    send(v1);
    wait_out(r);
    chk("midrst_next_block", r, e1);
    @(negedge clk);

    // round trip with random gaps on both sides
    rt_mode = 1'b1;
    nrecv = 0;
    fork
      begin
        for (int n = 0; n < N_RT; n++) begin
          logic [BLOCK_W-1:0] o;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          o = rand_blk();
          orig_q.push_back(o);
          send(mix_block(o));
        end
      end
      begin
        int guard;
        guard = 0;
        while (nrecv < N_RT && guard < 60000) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          guard++;
        end
      end
    join
    out_ready = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    chk("rt_count", nrecv, N_RT);
    chk("rt_orig_drained", orig_q.size(), 0);
    chk("rt_scoreboard_drained", exp_q.size(), 0);
    rt_mode = 1'b0;

    // back-to-back: spacing between accepts
    acc_q.delete();
    in_data = rand_blk();
    in_valid = 1'b1;
    repeat (6 * SPACING) begin
      @(negedge clk);
      in_data = rand_blk();
    end
    in_valid = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    chk("b2b_accepts", acc_q.size() >= 5, 1'b1);
    for (int i = 1; i < acc_q.size(); i++)
      chk("b2b_spacing", acc_q[i] - acc_q[i-1], SPACING);
    chk("b2b_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
